// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, sample layout and helpers for the FFT readout path.
// A RAM word is {re[31:16], im[15:0]}, both two's complement.
package fft_pkg;

  localparam int FFT_N      = 4096;
  localparam int FFT_ADDR_W = 12;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } fft_sample_t;

  typedef logic [31:0] fft_pwr_t;

  // Mirror an address end-for-end; used when the FFT core leaves bins bit-reversed.
  function automatic logic [FFT_ADDR_W-1:0] fft_bitrev(input logic [FFT_ADDR_W-1:0] addr);
    logic [FFT_ADDR_W-1:0] rev;
    rev = '0;
    for (int i = 0; i < FFT_ADDR_W; i++) begin
      rev[i] = addr[FFT_ADDR_W-1-i];
    end
    return rev;
  endfunction

  // re^2 + im^2. Each square is at most 2^30, so the sum is at most 2^31 and
  // always fits an unsigned 32-bit result without saturation.
  function automatic fft_pwr_t fft_power(input fft_sample_t s);
    logic signed [31:0] re_x;
    logic signed [31:0] im_x;
    logic signed [31:0] re_sq;
    logic signed [31:0] im_sq;
    re_x  = {{16{s.re[15]}}, s.re};
    im_x  = {{16{s.im[15]}}, s.im};
    re_sq = re_x * re_x;
    im_sq = im_x * im_x;
    return $unsigned(re_sq) + $unsigned(im_sq);
  endfunction

endpackage

// File: rtl/fft_unload_fifo.sv
// fft_unload_fifo: two-entry synchronous FIFO holding unpacked bins
// ({sample, pwr, bin, last} flattened by the caller). The head entry is
// presented combinationally from storage, so it is stable until popped.
module fft_unload_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [1:0]       count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop on an empty FIFO is dropped; a push into a full FIFO only lands
  // if the head leaves in the same cycle.
  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign rdata   = mem[rd_ptr];
  assign empty   = (count == 2'd0);

  // Storage, pointers and occupancy; simultaneous push and pop keep the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (do_push && !do_pop) begin
        count <= count + 2'd1;
      end else if (do_pop && !do_push) begin
        count <= count - 2'd1;
      end
    end
  end

endmodule

// File: rtl/fft_unloader.sv
// fft_unloader: walks the FFT result RAM after fft_4096 finishes, unpacks each
// word, computes re^2+im^2 and streams bins over valid/ready with index and
// last flag. Reads are credit-limited so nothing is lost under backpressure.
// Optional feature: define FFT_UNLOADER_BITREV_EN to read the RAM in
// bit-reversed address order while still emitting bins in natural order
// (that path uses fft_pkg::fft_bitrev, so ADDR_W must equal FFT_ADDR_W).
module fft_unloader
  import fft_pkg::*;
#(
  parameter int N_POINTS = FFT_N,
  parameter int ADDR_W   = FFT_ADDR_W,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_re,
  output logic [15:0]       out_im,
  output logic [31:0]       out_pwr,
  output logic [ADDR_W-1:0] out_bin,
  output logic              out_last
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int                ENTRY_W  = 32 + 32 + ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(N_POINTS - 1);

  state_t              state;
  logic [ADDR_W-1:0]   rd_cnt;
  logic                fly;
  logic [ADDR_W-1:0]   fly_bin;
  logic [1:0]          fifo_count;
  logic                fifo_empty;
  logic                fifo_pop;
  logic [2:0]          pending;
  fft_sample_t         rd_sample;
  logic [ENTRY_W-1:0]  push_entry;
  logic [ENTRY_W-1:0]  head_entry;

  // Bins held or on their way: FIFO entries plus the read in flight, less
  // the head leaving this cycle. Issuing only below two keeps the FIFO from
  // overflowing while still sustaining one bin per cycle with out_ready high.
  assign pending   = {1'b0, fifo_count} + {2'b00, fly} - {2'b00, fifo_pop};
  assign ram_rd_en = (state == RUN) && (pending < 3'd2);

`ifdef FFT_UNLOADER_BITREV_EN
  assign ram_addr = fft_bitrev(rd_cnt);
`else
  assign ram_addr = rd_cnt;
`endif

  assign rd_sample  = ram_rdata[31:0];
  assign push_entry = {rd_sample, fft_power(rd_sample), fly_bin, (fly_bin == LAST_BIN)};

  assign out_valid = !fifo_empty;
  assign fifo_pop  = out_valid && out_ready;
  assign {out_re, out_im, out_pwr, out_bin, out_last} = head_entry;

  // Control FSM: accepts start in IDLE only, steps the read counter without
  // wrapping, waits for the last handshake, then pulses done for one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      rd_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            busy   <= 1'b1;
            rd_cnt <= '0;
          end
        end
        RUN: begin
          if (ram_rd_en) begin
            if (rd_cnt == LAST_BIN) begin
              state <= DRAIN;
            end else begin
              rd_cnt <= rd_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (fifo_pop && out_last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          rd_cnt <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Track the read issued last cycle; its data arrives now and is pushed
  // together with the bin index it was issued for.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fly     <= 1'b0;
      fly_bin <= '0;
    end else begin
      fly     <= ram_rd_en;
      fly_bin <= rd_cnt;
    end
  end

  fft_unload_fifo #(
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fly),
    .pop   (fifo_pop),
    .wdata (push_entry),
    .rdata (head_entry),
    .count (fifo_count),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_fft_unloader.sv
// tb_fft_unloader: directed bench for fft_unloader with a behavioural
// synchronous-read RAM, a scoreboard of every delivered bin and a table of
// hand-computed bins. Honours FFT_UNLOADER_BITREV_EN for the expected order.
module tb_fft_unloader;
  import fft_pkg::*;

  localparam int N  = FFT_N;
  localparam int AW = FFT_ADDR_W;
`ifdef FFT_UNLOADER_BITREV_EN
  localparam bit BITREV = 1'b1;
`else
  localparam bit BITREV = 1'b0;
`endif

  typedef struct {
    int          addr;
    logic        plant;
    logic [31:0] word;
    int          bin_nat;
    int          bin_rev;
    logic [15:0] re;
    logic [15:0] im;
    logic [31:0] pwr;
    logic        last;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic          ram_rd_en;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rdata = 32'h0;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_re;
  logic [15:0]   out_im;
  logic [31:0]   out_pwr;
  logic [AW-1:0] out_bin;
  logic          out_last;

  logic [31:0]   mem [N];
  logic [15:0]   cap_re [N];
  logic [15:0]   cap_im [N];
  logic [31:0]   cap_pwr [N];
  logic          cap_last [N];
  vec_t          vecs [9];

  int total;
  int bad;
  bit mon_en;
  int ready_mode;
  int cyc, exp_bin, issued, popped, done_cnt;
  int start_cyc, first_cyc, last_cyc, done_cyc;
  bit prev_hold;
  logic [127:0] hold_snap;

  always #5 clk = ~clk;

  // Synchronous-read RAM: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (ram_rd_en) ram_rdata <= mem[ram_addr];
  end

  fft_unloader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .ram_rd_en (ram_rd_en),
    .ram_addr  (ram_addr),
    .ram_rdata (ram_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_pwr   (out_pwr),
    .out_bin   (out_bin),
    .out_last  (out_last)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int tbBitrev(input int a);
    int r;
    r = 0;
    for (int i = 0; i < AW; i++) if (a[i]) r = r | (1 << (AW - 1 - i));
    return r;
  endfunction

  function automatic int addrOf(input int b);
    return BITREV ? tbBitrev(b) : b;
  endfunction

  function automatic logic [127:0] outsVec();
    return 128'({busy, done, ram_rd_en, ram_addr, out_valid, out_re, out_im, out_pwr, out_bin, out_last});
  endfunction

  function automatic logic [127:0] snap();
    return 128'({out_valid, out_re, out_im, out_pwr, out_bin, out_last});
  endfunction

  task automatic resetMonitor();
    cyc = 0; exp_bin = 0; issued = 0; popped = 0; done_cnt = 0;
    start_cyc = -1; first_cyc = -1; last_cyc = -1; done_cyc = -1;
    prev_hold = 1'b0; hold_snap = '0;
  endtask

  // Compare the bin leaving now against the RAM contents it should come from.
  task automatic checkBin();
    logic [31:0] w;
    int r, m;
    longint p;
    if (exp_bin >= N) begin
      checkOutput("bin_overrun", 128'(exp_bin), 128'(N - 1));
    end else begin
      w = mem[addrOf(exp_bin)];
      r = int'($signed(w[31:16]));
      m = int'($signed(w[15:0]));
      p = longint'(r) * longint'(r) + longint'(m) * longint'(m);
      checkOutput("bin_index", 128'(out_bin), 128'(exp_bin));
      checkOutput("bin_re", 128'(out_re), 128'(w[31:16]));
      checkOutput("bin_im", 128'(out_im), 128'(w[15:0]));
      checkOutput("bin_pwr", 128'(out_pwr), 128'(p[31:0]));
      checkOutput("bin_last", 128'(out_last), 128'(exp_bin == N - 1));
      cap_re[exp_bin]   = out_re;
      cap_im[exp_bin]   = out_im;
      cap_pwr[exp_bin]  = out_pwr;
      cap_last[exp_bin] = out_last;
    end
  endtask

  task automatic sampleCycle();
    bit hs;
    hs = out_valid && out_ready;
    cyc++;
    if (start && start_cyc < 0) begin
      start_cyc = cyc;
      checkOutput("busy_before_start", 128'(busy), 128'(0));
    end
    if (start_cyc >= 0 && cyc == start_cyc + 1) checkOutput("busy_after_start", 128'(busy), 128'(1));
    if (prev_hold) checkOutput("hold_stable", snap(), hold_snap);
    if (ram_rd_en) checkOutput("read_credit", 128'((issued - popped - (hs ? 1 : 0)) < 2), 128'(1));
    if (out_valid && first_cyc < 0) first_cyc = cyc;
    if (hs) begin
      checkBin();
      if (out_last) last_cyc = cyc;
      popped++;
      exp_bin++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      checkOutput("busy_at_done", 128'(busy), 128'(0));
    end
    if (ram_rd_en) issued++;
    prev_hold = out_valid && !out_ready;
    hold_snap = snap();
  endtask

  task automatic monitorLoop();
    forever begin
      @(negedge clk);
      if (mon_en) sampleCycle();
    end
  endtask

  task automatic readyLoop();
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitDone(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      if (done_cnt > 0) break;
    end
    checkOutput("done_seen", 128'(done_cnt > 0), 128'(1));
  endtask

  initial begin
    total = 0;
    bad = 0;
    mon_en = 1'b0;
    ready_mode = 0;
    out_ready = 1'b1;
    resetMonitor();

    //           addr plant word          nat   rev   re        im        pwr            last
    vecs[0] = '{0,    1'b0, 32'h0,        0,    0,    16'h0000, 16'h0000, 32'd0,         1'b0};
    vecs[1] = '{1,    1'b0, 32'h0,        1,    2048, 16'h0001, 16'hFFFF, 32'd2,         1'b0};
    vecs[2] = '{5,    1'b0, 32'h0,        5,    2560, 16'h0005, 16'hFFFB, 32'd50,        1'b0};
    vecs[3] = '{7,    1'b1, 32'h80008000, 7,    3584, 16'h8000, 16'h8000, 32'h80000000,  1'b0};
    vecs[4] = '{9,    1'b1, 32'h7FFF8000, 9,    2304, 16'h7FFF, 16'h8000, 32'h7FFF0001,  1'b0};
    vecs[5] = '{100,  1'b0, 32'h0,        100,  608,  16'h0064, 16'hFF9C, 32'd20000,     1'b0};
    vecs[6] = '{3072, 1'b0, 32'h0,        3072, 3,    16'h0C00, 16'hF400, 32'd18874368,  1'b0};
    vecs[7] = '{4094, 1'b0, 32'h0,        4094, 2047, 16'h0FFE, 16'hF002, 32'd33521672,  1'b0};
    vecs[8] = '{4095, 1'b0, 32'h0,        4095, 4095, 16'h0FFF, 16'hF001, 32'd33538050,  1'b1};

    for (int i = 0; i < N; i++) mem[i] = {16'(i), 16'(-i)};
    for (int v = 0; v < 9; v++) if (vecs[v].plant) mem[vecs[v].addr] = vecs[v].word;

    fork
      monitorLoop();
      readyLoop();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1 checkOutput("reset_outputs", outsVec(), 128'(0));
    @(negedge clk) reset = 1'b1;

    // Full readout with out_ready high, plus a start pulse while busy
    @(posedge clk);
    #2 mon_en = 1'b1;
    applyStimulus();
    repeat (600) @(posedge clk);
    applyStimulus();
    waitDone(20000);
    repeat (5) @(posedge clk);
    // start is seen at the negedge before its sampling edge, so valid lands 3 samples later
    checkOutput("first_valid_latency", 128'(first_cyc - start_cyc), 128'(3));
    checkOutput("last_handshake_cycle", 128'(last_cyc - start_cyc), 128'(N + 2));
    checkOutput("done_delay", 128'(done_cyc - last_cyc), 128'(1));
    checkOutput("bins_delivered", 128'(exp_bin), 128'(N));
    checkOutput("done_pulses", 128'(done_cnt), 128'(1));
    checkOutput("idle_after_done", 128'({busy, ram_rd_en, out_valid}), 128'(0));

    for (int v = 0; v < 9; v++) begin
      int b;
      b = BITREV ? vecs[v].bin_rev : vecs[v].bin_nat;
      checkOutput($sformatf("vec%0d_re", v), 128'(cap_re[b]), 128'(vecs[v].re));
      checkOutput($sformatf("vec%0d_im", v), 128'(cap_im[b]), 128'(vecs[v].im));
      checkOutput($sformatf("vec%0d_pwr", v), 128'(cap_pwr[b]), 128'(vecs[v].pwr));
      checkOutput($sformatf("vec%0d_last", v), 128'(cap_last[b]), 128'(vecs[v].last));
    end

    // Random backpressure over a full readout
    mon_en = 1'b0;
    resetMonitor();
    ready_mode = 1;
    @(posedge clk);
    #2 mon_en = 1'b1;
    applyStimulus();
    waitDone(30000);
    repeat (5) @(posedge clk);
    checkOutput("bp_bins_delivered", 128'(exp_bin), 128'(N));
    checkOutput("bp_done_pulses", 128'(done_cnt), 128'(1));

    // Asynchronous reset mid-readout under backpressure, then a clean restart
    mon_en = 1'b0;
    resetMonitor();
    @(posedge clk);
    #2 mon_en = 1'b1;
    applyStimulus();
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk);
      if (exp_bin >= 1000) break;
    end
    checkOutput("reached_bin_1000", 128'(exp_bin >= 1000), 128'(1));
    ready_mode = 2;
    repeat (3) @(posedge clk);
    #2 checkOutput("valid_before_reset", 128'(out_valid), 128'(1));
    mon_en = 1'b0;
    reset = 1'b0;
    #1 checkOutput("async_reset_outputs", outsVec(), 128'(0));
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    #1 checkOutput("outputs_after_release", outsVec(), 128'(0));
    resetMonitor();
    ready_mode = 0;
    @(posedge clk);
    #2 mon_en = 1'b1;
    applyStimulus();
    waitDone(20000);
    repeat (5) @(posedge clk);
    checkOutput("restart_bins_delivered", 128'(exp_bin), 128'(N));
    checkOutput("restart_done_pulses", 128'(done_cnt), 128'(1));

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
